// File: rtl/cpu_pkg.sv
// Shared definitions for the front-end control blocks.
//   pc_state_e       : run/halt sequencing states of the next-PC stage
//   PC_W             : program counter width
//   DEFAULT_START_PC : reset / restart fetch address
package cpu_pkg;

    localparam int PC_W = 16;

    localparam logic [PC_W-1:0] DEFAULT_START_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: a LIFO addressed by its own fill count.
// Ports:
//   CLK, reset_ctrl : clock, asynchronous active-high reset (empties the stack)
//   push, pop       : one operation per cycle; a push while full and a pop
//                     while empty are ignored here (the caller flags them)
//   clear           : empties the stack, takes precedence over push/pop
//   din             : value pushed
//   top             : most recently pushed entry (undefined contents when empty)
//   count           : number of valid entries
//   full, empty     : count == DEPTH / count == 0
module ras_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = PC_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             reset_ctrl,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    // DEPTH is a power of two, so the low bits of count are the next free
    // slot and one below them (wrapping when full) is the top entry.
    assign wr_idx  = count[IDX_W-1:0];
    assign top_idx = wr_idx - IDX_W'(1);
    assign top     = mem[top_idx];

    always_ff @(posedge CLK or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CNT_W'(1);
        end else if (do_pop) begin
            count <= count - CNT_W'(1);
        end
    end

    // Storage is left alone on pop/clear; only the count decides validity.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC generation stage feeding the PC register.
// Ports:
//   CLK, reset_ctrl      : clock, asynchronous active-high reset
//   pc_in                : current PC fed back from the PC register
//   start                : begin / restart execution (ignored while running)
//   stall                : hold the PC this cycle
//   halt_req             : halt instruction decoded
//   branch_en, cond_flag : conditional branch and its ALU condition
//   branch_off           : signed PC-relative branch offset
//   jump_en, jump_target : absolute jump and its target (also the call target)
//   call_en, ret_en      : call (pushes pc_in+1) / return (pops the RAS)
//   pcnext_out           : combinational next PC, loaded on the next CLK edge
//   running, done        : state is RUN / HALTED
//   ras_err              : sticky RAS overflow/underflow
//   ras_count            : valid RAS entries
module next_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] START_PC  = DEFAULT_START_PC,
    parameter int              OFF_W     = 8,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           reset_ctrl,
    input  logic [PC_W-1:0]                pc_in,
    input  logic                           start,
    input  logic                           stall,
    input  logic                           halt_req,
    input  logic                           branch_en,
    input  logic                           cond_flag,
    input  logic [OFF_W-1:0]               branch_off,
    input  logic                           jump_en,
    input  logic [PC_W-1:0]                jump_target,
    input  logic                           call_en,
    input  logic                           ret_en,
    output logic [PC_W-1:0]                pcnext_out,
    output logic                           running,
    output logic                           done,
    output logic                           ras_err,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] ras_top;
    logic            ras_full, ras_empty;
    logic            ras_push, ras_pop, ras_clear;
    logic            err_set, err_clr;

    // All PC arithmetic wraps modulo 2^16 by width truncation.
    assign pc_inc    = pc_in + PC_W'(1);
    assign br_target = pc_in + PC_W'($signed(branch_off));

    assign running = (state_q == RUN);
    assign done    = (state_q == HALTED);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .CLK        (CLK),
        .reset_ctrl (reset_ctrl),
        .push       (ras_push),
        .pop        (ras_pop),
        .clear      (ras_clear),
        .din        (pc_inc),
        .top        (ras_top),
        .count      (ras_count),
        .full       (ras_full),
        .empty      (ras_empty)
    );

    always_ff @(posedge CLK or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            state_q <= IDLE;
            ras_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_clr) begin
                ras_err <= 1'b0;
            end else if (err_set) begin
                ras_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pcnext_out = pc_in;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        ras_clear  = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                pcnext_out = START_PC;
                if (start) state_d = RUN;
            end
            RUN: begin
                // First match wins; a stall masks everything, including halt.
                if (stall) begin
                    pcnext_out = pc_in;
                end else if (halt_req) begin
                    pcnext_out = pc_in;
                    state_d    = HALTED;
                end else if (ret_en) begin
                    if (!ras_empty) begin
                        pcnext_out = ras_top;
                        ras_pop    = 1'b1;
                    end else begin
                        pcnext_out = pc_inc;
                        err_set    = 1'b1;
                    end
                end else if (call_en) begin
                    pcnext_out = jump_target;
                    if (!ras_full) ras_push = 1'b1;
                    else           err_set  = 1'b1;
                end else if (jump_en) begin
                    pcnext_out = jump_target;
                end else if (branch_en && cond_flag) begin
                    pcnext_out = br_target;
                end else begin
                    pcnext_out = pc_inc;
                end
            end
            HALTED: begin
                // Restart behaves like a fresh start: new PC, empty RAS, no error.
                if (start) begin
                    pcnext_out = START_PC;
                    state_d    = RUN;
                    ras_clear  = 1'b1;
                    err_clr    = 1'b1;
                end
            end
            default: begin
                pcnext_out = START_PC;
                state_d    = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;
    import cpu_pkg::*;

    localparam int RAS_DEPTH = 4;
    localparam int CW        = $clog2(RAS_DEPTH + 1);

    logic          CLK = 1'b0;
    logic          reset_ctrl;
    logic [15:0]   pc_in;
    logic          start, stall, halt_req, branch_en, cond_flag;
    logic [7:0]    branch_off;
    logic          jump_en, call_en, ret_en;
    logic [15:0]   jump_target;
    logic [15:0]   pcnext_out;
    logic          running, done, ras_err;
    logic [CW-1:0] ras_count;

    typedef struct {
        string         tag;
        logic [15:0]   pc;
        logic          run;
        logic          dn;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    next_pc_unit #(
        .START_PC  (16'h0000),
        .OFF_W     (8),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .CLK         (CLK),
        .reset_ctrl  (reset_ctrl),
        .pc_in       (pc_in),
        .start       (start),
        .stall       (stall),
        .halt_req    (halt_req),
        .branch_en   (branch_en),
        .cond_flag   (cond_flag),
        .branch_off  (branch_off),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .pcnext_out  (pcnext_out),
        .running     (running),
        .done        (done),
        .ras_err     (ras_err),
        .ras_count   (ras_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input string tag, input logic [15:0] pc, input logic run,
                              input logic dn, input logic err, input logic [CW-1:0] cnt);
        exp_t e;
        e.tag = tag; e.pc = pc; e.run = run; e.dn = dn; e.err = err; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic check_one(input string tag, input string field,
                             input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    endtask

    task automatic sample();
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        check_one(e.tag, "pcnext", pcnext_out, e.pc);
        check_one(e.tag, "running", {15'd0, running}, {15'd0, e.run});
        check_one(e.tag, "done", {15'd0, done}, {15'd0, e.dn});
        check_one(e.tag, "ras_err", {15'd0, ras_err}, {15'd0, e.err});
        check_one(e.tag, "ras_count", {13'd0, ras_count}, {13'd0, e.cnt});
    endtask

    // Inputs are driven just after a rising edge; outputs are checked on the
    // falling edge, then the rising edge commits the cycle.
    task automatic tick();
        @(negedge CLK);
        sample();
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input string tag, input logic [15:0] pcv, input logic [15:0] pc,
                        input logic run, input logic dn, input logic err,
                        input logic [CW-1:0] cnt);
        pc_in = pcv;
        expect_out(tag, pc, run, dn, err, cnt);
        tick();
    endtask

    task automatic no_req();
        start = 0; stall = 0; halt_req = 0; branch_en = 0; cond_flag = 0;
        branch_off = 8'h00; jump_en = 0; call_en = 0; ret_en = 0; jump_target = 16'h0000;
    endtask

    initial begin
        no_req();
        pc_in      = 16'h1234;
        reset_ctrl = 1'b1;
        #3;
        expect_out("reset", 16'h0000, 0, 0, 0, 0);
        sample();
        #9 reset_ctrl = 1'b0;

        // Idle ignores pc_in and drives START_PC.
        step("idle0", 16'h1234, 16'h0000, 0, 0, 0, 0);
        step("idle1", 16'h1234, 16'h0000, 0, 0, 0, 0);
        step("idle2", 16'h1234, 16'h0000, 0, 0, 0, 0);
        start = 1;
        step("start", 16'h1234, 16'h0000, 0, 0, 0, 0);
        start = 0;
        step("seq1", 16'h0000, 16'h0001, 1, 0, 0, 0);
        step("seq2", 16'h0001, 16'h0002, 1, 0, 0, 0);
        step("seq3", 16'h0002, 16'h0003, 1, 0, 0, 0);
        start = 1;
        step("start_in_run", 16'h0003, 16'h0004, 1, 0, 0, 0);
        start = 0;

        // Branches and wrap.
        branch_en = 1; cond_flag = 1; branch_off = 8'hFD;
        step("br_taken", 16'h0010, 16'h000D, 1, 0, 0, 0);
        cond_flag = 0;
        step("br_not_taken", 16'h0010, 16'h0011, 1, 0, 0, 0);
        cond_flag = 1; branch_off = 8'hFC;
        step("br_wrap_neg", 16'h0002, 16'hFFFE, 1, 0, 0, 0);
        no_req();
        step("wrap", 16'hFFFF, 16'h0000, 1, 0, 0, 0);
        jump_en = 1; jump_target = 16'h0200;
        step("jump", 16'h0005, 16'h0200, 1, 0, 0, 0);
        no_req();

        // Single call / return.
        call_en = 1; jump_target = 16'h0100;
        step("call", 16'h0020, 16'h0100, 1, 0, 0, 0);
        no_req();
        step("after_call", 16'h0100, 16'h0101, 1, 0, 0, 1);
        ret_en = 1;
        step("ret", 16'h0150, 16'h0021, 1, 0, 0, 1);
        no_req();
        step("after_ret", 16'h0021, 16'h0022, 1, 0, 0, 0);

        // Five nested calls overflow a four-deep stack.
        call_en = 1; jump_target = 16'h0400;
        for (int i = 0; i < 5; i++)
            step($sformatf("nest_call%0d", i), 16'h0030 + 16'(i) * 16'h0010, 16'h0400,
                 1, 0, 0, CW'(i));
        no_req();
        ret_en = 1;
        step("nest_ret0", 16'h0500, 16'h0061, 1, 0, 1, 4);
        step("nest_ret1", 16'h0500, 16'h0051, 1, 0, 1, 3);
        step("nest_ret2", 16'h0500, 16'h0041, 1, 0, 1, 2);
        step("nest_ret3", 16'h0500, 16'h0031, 1, 0, 1, 1);
        step("underflow", 16'h0600, 16'h0601, 1, 0, 1, 0);
        no_req();
        step("after_uf", 16'h0601, 16'h0602, 1, 0, 1, 0);

        // Priority: stall masks halt, jump and call.
        stall = 1; halt_req = 1; jump_en = 1; call_en = 1; jump_target = 16'h0900;
        step("stall_prio", 16'h0700, 16'h0700, 1, 0, 1, 0);
        no_req();
        halt_req = 1;
        step("halt", 16'h0701, 16'h0701, 1, 0, 1, 0);
        no_req();
        jump_en = 1; jump_target = 16'h0900;
        step("halted_frozen", 16'h0702, 16'h0702, 0, 1, 1, 0);
        no_req();
        start = 1;
        step("restart", 16'h0702, 16'h0000, 0, 1, 1, 0);
        no_req();
        step("after_restart", 16'h0000, 16'h0001, 1, 0, 0, 0);

        // Async reset mid-run with two entries on the stack.
        call_en = 1; jump_target = 16'h0800;
        step("rst_call0", 16'h0080, 16'h0800, 1, 0, 0, 0);
        step("rst_call1", 16'h0090, 16'h0800, 1, 0, 0, 1);
        no_req();
        pc_in = 16'h0123;
        expect_out("pre_rst", 16'h0124, 1, 0, 0, 2);
        #2 sample();
        reset_ctrl = 1'b1;
        expect_out("async_rst", 16'h0000, 0, 0, 0, 0);
        #1 sample();
        #3 reset_ctrl = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
